// File: rtl/execute_stage.sv
// Y86-64 Execute stage: operand select, ripple-add ALU, condition codes, Cnd and the E/M register.
// e_* outputs are combinational; M_* and cc_out update one clock later; M_stall freezes E/M and CC.

module exec_ripple_add #(
    parameter int W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o
);

    logic [W-1:0] carry;

    assign carry[0] = c_i;

    // The final carry is not produced at all: every caller works mod 2^W.
    for (genvar g = 0; g < W; g++) begin : g_fa
        assign sum_o[g] = a_i[g] ^ b_i[g] ^ carry[g];
        if (g < W - 1) begin : g_carry
            assign carry[g+1] = (a_i[g] & b_i[g]) | (carry[g] & (a_i[g] ^ b_i[g]));
        end
    end

endmodule

module execute_stage #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [W-1:0] E_valC,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [3:0]   m_stat,
    input  logic [3:0]   W_stat,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_dstE,
    output logic         e_Cnd,
    output logic [3:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM,
    output logic [2:0]   cc_out
);

    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] A_ADD = 4'h0;
    localparam logic [3:0] A_SUB = 4'h1;
    localparam logic [3:0] A_AND = 4'h2;
    localparam logic [3:0] A_XOR = 4'h3;

    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [W-1:0] PLUS8  = W'(8);
    localparam logic [W-1:0] MINUS8 = ~(W'(7));
    localparam logic [2:0]   CC_RST = 3'b100;

    typedef struct packed {
        logic [3:0]   stat;
        logic [3:0]   icode;
        logic         cnd;
        logic [W-1:0] val_e;
        logic [W-1:0] val_a;
        logic [3:0]   dst_e;
        logic [3:0]   dst_m;
    } em_t;

    localparam em_t EM_BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        cnd:   1'b0,
        val_e: '0,
        val_a: '0,
        dst_e: RNONE,
        dst_m: RNONE
    };

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] add_b;
    logic [W-1:0] add_sum;
    logic [W-1:0] alu_res;
    logic [3:0]   alufun;
    logic         is_sub;
    logic         zf;
    logic         sf;
    logic         of;
    logic         set_cc;
    logic         cnd;
    logic         lt;
    logic [2:0]   cc_d;
    logic [2:0]   cc_q;
    em_t          em_d;
    em_t          em_q;

    always_comb begin
        alu_a = '0;
        case (E_icode)
            I_CMOV, I_OPQ:            alu_a = E_valA;
            I_IRMOV, I_RMMOV, I_MRMOV: alu_a = E_valC;
            I_CALL, I_PUSH:           alu_a = MINUS8;
            I_RET, I_POP:             alu_a = PLUS8;
            default:                  alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (E_icode)
            I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = E_valB;
            default:                                                alu_b = '0;
        endcase
    end

    assign alufun = (E_icode == I_OPQ) ? E_ifun : A_ADD;
    assign is_sub = (alufun == A_SUB);

    // Subtraction shares the adder: aluB + ~aluA + 1.
    assign add_b = is_sub ? ~alu_a : alu_a;

    exec_ripple_add #(.W(W)) u_add (
        .a_i   (alu_b),
        .b_i   (add_b),
        .c_i   (is_sub),
        .sum_o (add_sum)
    );

    always_comb begin
        alu_res = '0;
        of      = 1'b0;
        case (alufun)
            A_ADD: begin
                alu_res = add_sum;
                of      = (alu_a[W-1] == alu_b[W-1]) && (add_sum[W-1] != alu_a[W-1]);
            end
            A_SUB: begin
                alu_res = add_sum;
                of      = (alu_a[W-1] != alu_b[W-1]) && (add_sum[W-1] != alu_b[W-1]);
            end
            A_AND:   alu_res = alu_a & alu_b;
            A_XOR:   alu_res = alu_a ^ alu_b;
            default: alu_res = '0;
        endcase
    end

    assign zf = (alu_res == '0);
    assign sf = alu_res[W-1];

    function automatic logic stat_exc(input logic [3:0] s);
        return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
    endfunction

    assign set_cc = (E_icode == I_OPQ) && !stat_exc(m_stat) && !stat_exc(W_stat)
                    && !M_stall && !reset;

    always_comb begin
        cc_d = cc_q;
        if (set_cc) begin
            cc_d = {zf, sf, of};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cc_q <= CC_RST;
        end else begin
            cc_q <= cc_d;
        end
    end

    // Cnd looks only at the registered flags, never at this cycle's ALU result.
    assign lt = cc_q[1] ^ cc_q[0];

    always_comb begin
        cnd = 1'b0;
        case (E_ifun)
            4'h0:    cnd = 1'b1;
            4'h1:    cnd = lt | cc_q[2];
            4'h2:    cnd = lt;
            4'h3:    cnd = cc_q[2];
            4'h4:    cnd = !cc_q[2];
            4'h5:    cnd = !lt;
            4'h6:    cnd = !lt && !cc_q[2];
            default: cnd = 1'b0;
        endcase
    end

    assign e_valE = alu_res;
    assign e_Cnd  = cnd;
    assign e_dstE = ((E_icode == I_CMOV) && !cnd) ? RNONE : E_dstE;

    always_comb begin
        em_d = em_q;
        if (!M_stall) begin
            if (M_bubble) begin
                em_d = EM_BUBBLE;
            end else begin
                em_d = '{
                    stat:  E_stat,
                    icode: E_icode,
                    cnd:   cnd,
                    val_e: alu_res,
                    val_a: E_valA,
                    dst_e: e_dstE,
                    dst_m: E_dstM
                };
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            em_q <= EM_BUBBLE;
        end else begin
            em_q <= em_d;
        end
    end

    assign M_stat  = em_q.stat;
    assign M_icode = em_q.icode;
    assign M_Cnd   = em_q.cnd;
    assign M_valE  = em_q.val_e;
    assign M_valA  = em_q.val_a;
    assign M_dstE  = em_q.dst_e;
    assign M_dstM  = em_q.dst_m;
    assign cc_out  = cc_q;

endmodule
